// File: rtl/rider_steer_en.sv
// rider_steer_en: rider-detect / steering-enable qualifier.
// Registers the sum and absolute difference of the two load-cell readings,
// then runs a three-state FSM (IDLE / WAIT / STEER) with a saturating settle
// timer. Optional battery cutoff is compiled in with RIDER_BATT_CUTOFF_EN.
module rider_steer_en #(
    parameter int                  DATA_W       = 12,
    parameter logic [DATA_W-1:0]   MIN_RIDER_WT = 12'h200,
    parameter logic [DATA_W-1:0]   WT_HYST      = 12'h040,
    parameter int                  TMR_W        = 26,
    parameter logic [DATA_W-1:0]   BATT_MIN     = 12'h800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_vld,
    input  logic [DATA_W-1:0] lft_ld,
    input  logic [DATA_W-1:0] rght_ld,
    input  logic [DATA_W-1:0] batt,
    output logic              en_steer,
    output logic              rider_off,
    output logic              batt_low
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    // Rider-lost threshold, kept one bit wider than the readings so the
    // comparison against the 13-bit sum never truncates.
    localparam logic [DATA_W:0] RIDER_THR = {1'b0, MIN_RIDER_WT};
    localparam logic [DATA_W:0] LOST_THR  = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    // Absolute difference of two unsigned readings.
    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        return (&v) ? v : (v + {{(TMR_W-1){1'b0}}, 1'b1});
    endfunction

    state_t            state;
    state_t            nxt_state;
    logic              clr_tmr;
    logic [TMR_W-1:0]  tmr;
    logic              tmr_full;

    logic [DATA_W:0]   sum_q;
    logic [DATA_W-1:0] diff_q;

    logic              rider_gt;
    logic              rider_lt;
    logic              diff_gt_1_4;
    logic              diff_gt_15_16;
    logic              batt_ok;

    // ---- Qualification stage: sum / difference captured on each fresh sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            diff_q <= '0;
        end else if (ld_vld) begin
            sum_q  <= {1'b0, lft_ld} + {1'b0, rght_ld};
            diff_q <= abs_diff(lft_ld, rght_ld);
        end
    end

    // ---- Threshold compares on the registered values (13-bit unsigned)
    always_comb begin
        rider_gt      = (sum_q > RIDER_THR);
        rider_lt      = (sum_q <= LOST_THR);
        diff_gt_1_4   = ({1'b0, diff_q} > (sum_q >> 2));
        diff_gt_15_16 = ({1'b0, diff_q} > (sum_q - (sum_q >> 4)));
    end

`ifdef RIDER_BATT_CUTOFF_EN
    logic [DATA_W-1:0] batt_q;
    logic              batt_low_q;

    // Battery sample follows the load samples; the low flag lags it by a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            batt_q     <= '0;
            batt_low_q <= 1'b0;
        end else begin
            if (ld_vld) begin
                batt_q <= batt;
            end
            batt_low_q <= (batt_q < BATT_MIN);
        end
    end

    assign batt_low = batt_low_q;
    assign batt_ok  = ~batt_low_q;
`else
    // Battery reading is intentionally ignored in this build.
    logic unused_batt;
    assign unused_batt = ^{batt, BATT_MIN};
    assign batt_low    = 1'b0;
    assign batt_ok     = 1'b1;
`endif

    assign tmr_full = &tmr;

    // ---- Settle timer: clear wins over count, counts only in WAIT, saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (clr_tmr) begin
            tmr <= '0;
        end else if (state == WAIT) begin
            tmr <= sat_inc(tmr);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state logic and timer clear, in priority order per state.
    always_comb begin
        nxt_state = state;
        clr_tmr   = 1'b0;
        case (state)
            IDLE: begin
                if (rider_gt) begin
                    nxt_state = WAIT;
                    clr_tmr   = 1'b1;
                end
            end
            WAIT: begin
                if (rider_lt) begin
                    nxt_state = IDLE;
                end else if (diff_gt_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full && batt_ok) begin
                    nxt_state = STEER;
                end
            end
            STEER: begin
                if (rider_lt) begin
                    nxt_state = IDLE;
                end else if (diff_gt_15_16) begin
                    nxt_state = WAIT;
                    clr_tmr   = 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // ---- Output stage: Moore flags registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            en_steer  <= (nxt_state == STEER);
            rider_off <= (nxt_state == IDLE);
        end
    end

endmodule

// File: tb/tb_rider_steer_en.sv
// Self-checking bench for rider_steer_en (TMR_W = 4) against a behavioural
// model of the rider-qualification rules.
module tb_rider_steer_en;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_vld = 1'b0;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic [11:0] batt = 12'hFFF;
    logic        en_steer;
    logic        rider_off;
    logic        batt_low;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0 = no rider, 1 = settling, 2 = steering.
    int m_sum, m_diff, m_mode, m_cnt, m_bq;
    bit m_bl;

    rider_steer_en #(.TMR_W(4)) dut (
        .clk(clk), .rst(rst), .ld_vld(ld_vld), .lft_ld(lft_ld),
        .rght_ld(rght_ld), .batt(batt), .en_steer(en_steer),
        .rider_off(rider_off), .batt_low(batt_low)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_sum = 0; m_diff = 0; m_mode = 0; m_cnt = 0; m_bq = 0; m_bl = 0;
    endtask

    task automatic drive(input bit v, input int l, input int r);
        ld_vld  = v;
        lft_ld  = 12'(l);
        rght_ld = 12'(r);
    endtask

    // Advance one clock and apply the rules to the model; returns at edge+1.
    task automatic step();
        int  n_mode, n_cnt, lim;
        bit  clr, rider, lost, unbal, tip, n_bl;
        @(posedge clk);
        rider = (m_sum > 'h200);
        lost  = (m_sum <= 'h200 - 'h040);
        unbal = (m_diff > m_sum / 4);
        tip   = (m_diff > m_sum - m_sum / 16);
        lim   = 15;
        n_mode = m_mode;
        clr = 0;
        if (m_mode == 0) begin
            if (rider) begin n_mode = 1; clr = 1; end
        end else if (m_mode == 1) begin
            if (lost) n_mode = 0;
            else if (unbal) clr = 1;
            else if (m_cnt == lim && !m_bl) n_mode = 2;
        end else begin
            if (lost) n_mode = 0;
            else if (tip) begin n_mode = 1; clr = 1; end
        end
        if (clr) n_cnt = 0;
        else if (m_mode == 1) n_cnt = (m_cnt < lim) ? m_cnt + 1 : lim;
        else n_cnt = m_cnt;
`ifdef RIDER_BATT_CUTOFF_EN
        n_bl = (m_bq < 'h800);
        if (ld_vld) m_bq = int'(batt);
`else
        n_bl = 0;
`endif
        if (ld_vld) begin
            m_sum  = int'(lft_ld) + int'(rght_ld);
            m_diff = (lft_ld >= rght_ld) ? int'(lft_ld) - int'(rght_ld)
                                         : int'(rght_ld) - int'(lft_ld);
        end
        m_mode = n_mode;
        m_cnt  = n_cnt;
        m_bl   = n_bl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #12;
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1 || batt_low !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: en=%b off=%b bl=%b, want 0 1 0", en_steer, rider_off, batt_low);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (en_steer !== (m_mode == 2) || rider_off !== (m_mode == 0) || batt_low !== m_bl) begin
                errors++;
                $display("FAIL reset_idle c%0d: en=%b off=%b bl=%b, want %b %b %b", i,
                         en_steer, rider_off, batt_low, m_mode == 2, m_mode == 0, m_bl);
            end
        end
    endtask

    // Balanced rider: pulse, expect WAIT next edge, then STEER after the timer.
    task automatic test_enable();
        int cyc = 0;
        drive(1, 'h180, 'h180);
        step();
        drive(0, 'h180, 'h180);
        step();
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0) begin
            errors++;
            $display("FAIL enable_wait: en=%b off=%b, want 0 0", en_steer, rider_off);
        end
        while (m_mode != 2 && cyc < 40) begin
            step();
            cyc++;
            checks++;
            if (en_steer !== (m_mode == 2) || rider_off !== (m_mode == 0)) begin
                errors++;
                $display("FAIL enable_settle c%0d: en=%b off=%b, want %b %b", cyc,
                         en_steer, rider_off, m_mode == 2, m_mode == 0);
            end
        end
        checks++;
        if (en_steer !== 1'b1 || rider_off !== 1'b0 || cyc < 15) begin
            errors++;
            $display("FAIL enable_final: en=%b off=%b after %0d clks, want 1 0 after >=15", en_steer, rider_off, cyc);
        end
    endtask

    // Tip-over from STEER back to WAIT, then rider steps off to IDLE.
    task automatic test_tip_off();
        drive(1, 'h3F0, 'h010);
        step();
        drive(0, 0, 0);
        step();
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0 || m_mode != 1) begin
            errors++;
            $display("FAIL tip_wait: en=%b off=%b, want 0 0", en_steer, rider_off);
        end
        drive(1, 0, 0);
        step();
        drive(0, 0, 0);
        step();
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            errors++;
            $display("FAIL off_idle: en=%b off=%b, want 0 1", en_steer, rider_off);
        end
    endtask

    // Sustained imbalance in WAIT holds the timer at zero.
    task automatic test_unbalance();
        int cyc = 0;
        drive(1, 'h180, 'h180);
        step();
        step();
        step();
        for (int i = 0; i < 25; i++) begin
            drive(1, 'h300, 'h080);
            step();
            checks++;
            if (en_steer !== 1'b0 || rider_off !== 1'b0) begin
                errors++;
                $display("FAIL unbal_hold c%0d: en=%b off=%b, want 0 0", i, en_steer, rider_off);
            end
        end
        drive(1, 'h180, 'h180);
        step();
        drive(0, 'h180, 'h180);
        while (m_mode != 2 && cyc < 40) begin
            step();
            cyc++;
            checks++;
            if (en_steer !== (m_mode == 2)) begin
                errors++;
                $display("FAIL unbal_resettle c%0d: en=%b, want %b", cyc, en_steer, m_mode == 2);
            end
        end
        checks++;
        if (en_steer !== 1'b1 || cyc < 15) begin
            errors++;
            $display("FAIL unbal_steer: en=%b after %0d clks, want 1 after >=15", en_steer, cyc);
        end
    endtask

    // Exact rider threshold and hysteresis band.
    task automatic test_hyst();
        drive(1, 0, 0); step(); drive(0, 0, 0); step();
        drive(1, 'h100, 'h100); step(); drive(0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (rider_off !== 1'b1 || en_steer !== 1'b0) begin
                errors++;
                $display("FAIL thr_exact c%0d: off=%b en=%b, want 1 0", i, rider_off, en_steer);
            end
        end
        drive(1, 'h180, 'h180); step(); drive(0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (en_steer !== 1'b1) begin
            errors++;
            $display("FAIL hyst_setup: en=%b, want 1", en_steer);
        end
        drive(1, 'h0E8, 'h0E8); step(); drive(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (en_steer !== 1'b1 || rider_off !== 1'b0) begin
                errors++;
                $display("FAIL hyst_band c%0d: en=%b off=%b, want 1 0", i, en_steer, rider_off);
            end
        end
        drive(1, 'h0E0, 'h0E0); step(); drive(0, 0, 0); step();
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            errors++;
            $display("FAIL hyst_lost: en=%b off=%b, want 0 1", en_steer, rider_off);
        end
    endtask

    // Random loads clustered around the thresholds.
    task automatic test_random();
        int base, skew;
        for (int i = 0; i < 600; i++) begin
            base = int'($urandom_range(0, 'h180));
            skew = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'h100)) : int'($urandom_range(0, 8));
            drive($urandom_range(0, 7) == 0, base + skew, base);
            batt = ($urandom_range(0, 3) == 0) ? 12'h7FF : 12'h900;
            step();
            checks++;
            if (en_steer !== (m_mode == 2) || rider_off !== (m_mode == 0) || batt_low !== m_bl) begin
                errors++;
                $display("FAIL random c%0d: en=%b off=%b bl=%b, want %b %b %b", i,
                         en_steer, rider_off, batt_low, m_mode == 2, m_mode == 0, m_bl);
            end
        end
        batt = 12'hFFF;
    endtask

    // Asynchronous reset while steering forces outputs without a clock edge.
    task automatic test_async_reset();
        drive(1, 'h180, 'h180); step(); drive(0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1 || batt_low !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: en=%b off=%b bl=%b, want 0 1 0", en_steer, rider_off, batt_low);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 'h180, 'h180);
        step();
        checks++;
        if (rider_off !== 1'b1 || en_steer !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: off=%b en=%b, want 1 0", rider_off, en_steer);
        end
    endtask

`ifdef RIDER_BATT_CUTOFF_EN
    task automatic test_batt();
        batt = 12'h7FF;
        drive(1, 'h180, 'h180); step(); drive(0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (en_steer !== 1'b0 || (i > 2 && batt_low !== 1'b1)) begin
                errors++;
                $display("FAIL batt_low_hold c%0d: en=%b bl=%b, want 0 1", i, en_steer, batt_low);
            end
        end
        batt = 12'h800;
        drive(1, 'h180, 'h180); step(); drive(0, 0, 0); step();
        checks++;
        if (batt_low !== 1'b0) begin
            errors++;
            $display("FAIL batt_ok: bl=%b, want 0", batt_low);
        end
        step();
        checks++;
        if (en_steer !== 1'b1) begin
            errors++;
            $display("FAIL batt_steer: en=%b, want 1", en_steer);
        end
        batt = 12'hFFF;
    endtask
`endif

    initial begin
        test_reset();
        test_enable();
        test_tip_off();
        test_unbalance();
        test_hyst();
        test_async_reset();
`ifdef RIDER_BATT_CUTOFF_EN
        test_batt();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
